// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Build option: MEM_RO_REGION_EN (used by mem_responder) write-protects
// the low ROM_WORDS addresses of the RAM.
package mem_pkg;

  typedef logic [15:0] word_t;

  localparam word_t MMIO_OUT_ADDR    = 16'hFFFE;
  localparam word_t MMIO_CNT_ADDR    = 16'hFFFF;
  localparam int    MAX_READ_LATENCY = 4;

  // Target selected by an address.
  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_OUT  = 2'd1,
    SEL_CNT  = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

endpackage

// File: rtl/mem_read_pipe.sv
// Fixed-depth delay line for read data, with reset-to-zero stages.
// With STAGES = 0 the data passes straight through.
module mem_read_pipe
  import mem_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic  clk,
  input  logic  reset,
  input  word_t i_data,
  output word_t o_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_data = i_data;
    end else begin : g_delay
      word_t r_pipe [STAGES];

      // Shift read data one stage per cycle; reset drops everything in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= i_data;
          for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_data = r_pipe[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed RAM, an output register at 16'hFFFE
// and a free-running cycle counter at 16'hFFFF, behind one fixed-latency port.
// Build option: MEM_RO_REGION_EN makes addresses 0..ROM_WORDS-1 read-only.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1,
  parameter int ROM_WORDS    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] to_mem_addr,
  input  logic [15:0] core_to_mem_data,
  input  logic        core_to_mem_write_enable,
  output logic [15:0] from_mem_data,
  output logic [15:0] out_port,
  output logic        bad_addr
);

  localparam int AW = $clog2(DEPTH);

  // Out-of-range latencies are pulled into the supported 1..4 window.
  localparam int LAT = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                       (READ_LATENCY < 1)                ? 1 : READ_LATENCY;

`ifdef MEM_RO_REGION_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [16:0] ROM_W   = 17'(ROM_WORDS);

  word_t          r_mem [DEPTH];
  word_t          r_stage1;
  word_t          r_out;
  word_t          r_cnt;
  logic           r_bad;

  sel_e           w_sel;
  logic [AW-1:0]  w_ram_idx;
  logic           w_ro_hit;
  logic           w_ram_we;
  logic           w_bad;
  logic           w_pass_wdata;
  word_t          w_pipe_out;

  // Decode the request address into one target.
  always_comb begin
    // NOTE: default first so every path assigns w_sel and no latch is inferred.
    w_sel = SEL_NONE;
    if ({1'b0, to_mem_addr} < DEPTH_W)     w_sel = SEL_RAM;
    else if (to_mem_addr == MMIO_OUT_ADDR) w_sel = SEL_OUT;
    else if (to_mem_addr == MMIO_CNT_ADDR) w_sel = SEL_CNT;
  end

  assign w_ram_idx    = to_mem_addr[AW-1:0];
  assign w_ro_hit     = RO_EN && (w_sel == SEL_RAM) && ({1'b0, to_mem_addr} < ROM_W);
  assign w_ram_we     = core_to_mem_write_enable && (w_sel == SEL_RAM) && !w_ro_hit;
  assign w_bad        = (w_sel == SEL_NONE) || (core_to_mem_write_enable && w_ro_hit);
  // A protected write reports the stored word instead of the dropped data.
  assign w_pass_wdata = core_to_mem_write_enable && !w_ro_hit;

  // RAM write port.
  // NOTE: the array has no reset so it maps onto block RAM and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_idx] <= core_to_mem_data;
  end

  // First read stage: write-through data or the addressed target's current value.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      r_stage1 <= '0;
    end else if (w_pass_wdata) begin
      r_stage1 <= core_to_mem_data;
    end else begin
      case (w_sel)
        SEL_RAM: r_stage1 <= r_mem[w_ram_idx];
        SEL_OUT: r_stage1 <= r_out;
        SEL_CNT: r_stage1 <= r_cnt;
        default: r_stage1 <= '0;
      endcase
    end
  end

  // Memory-mapped output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (core_to_mem_write_enable && (w_sel == SEL_OUT)) begin
      r_out <= core_to_mem_data;
    end
  end

  // Free-running cycle counter; a write loads it instead of incrementing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (core_to_mem_write_enable && (w_sel == SEL_CNT)) begin
      r_cnt <= core_to_mem_data;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Sticky illegal-access flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bad <= 1'b0;
    end else if (w_bad) begin
      r_bad <= 1'b1;
    end
  end

  mem_read_pipe #(
    .STAGES (LAT - 1)
  ) u_read_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_data (r_stage1),
    .o_data (w_pipe_out)
  );

  assign from_mem_data = w_pipe_out;
  assign out_port      = r_out;
  assign bad_addr      = r_bad;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's single memory port. It accepts `to_mem_addr`, `core_to_mem_data` and `core_to_mem_write_enable` from the core, and returns `from_mem_data` after a fixed, parameterised latency.
- It holds a word-addressed synchronous RAM, a memory-mapped output register and a free-running cycle counter.
- It sits opposite the core in the top level and serves both instruction fetch and data access through one port, one request per cycle.

Parameters:
- DEPTH, 4096, number of 16-bit RAM words at addresses 0..DEPTH-1. Must be no greater than 16'hFFF0.
- READ_LATENCY, 1, cycles from address sample to data valid. Legal range 1..4.
- ROM_WORDS, 256, size of the write-protected low region. Used only with MEM_RO_REGION_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- to_mem_addr  input  16  word address, sampled every rising edge
- core_to_mem_data  input  16  write data
- core_to_mem_write_enable  input  1  1 = write cycle, 0 = read cycle
- from_mem_data  output  16  read data, READ_LATENCY cycles after the address
- out_port  output  16  memory-mapped output register
- bad_addr  output  1  sticky flag for an illegal access

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - from_mem_data = 0 and all read-pipeline stages = 0
  - out_port = 0, cycle counter = 0, bad_addr = 0
  - RAM contents are not cleared and are retained across reset.
- One request is taken every rising edge. There is no handshake and no stall; the core relies on fixed latency.
- Address map:
  - 0..DEPTH-1: RAM
  - 16'hFFFE: out_port, read/write
  - 16'hFFFF: cycle counter, read/write
  - all other addresses: unmapped
- Read, address A sampled at edge N:
  - Stage 1 registers the RAM word or MMIO value at edge N.
  - READ_LATENCY-1 further delay stages follow.
  - from_mem_data shows the value after edge N+READ_LATENCY-1, i.e. during cycle N+READ_LATENCY.
  - Back-to-back reads are fully pipelined, one result per cycle.
- Write cycle (write_enable = 1 at edge N):
  - The target updates at edge N.
  - The pipeline slot for that cycle carries core_to_mem_data (write-through), so from_mem_data at the matching latency equals the written value.
  - A read of the same address at edge N+1 returns the new data.
- Cycle counter:
  - 16-bit, increments every cycle out of reset, wraps 16'hFFFF to 0.
  - A read returns the pre-increment value at the sampling edge.
  - A write loads the data at edge N; the counter then increments from that value at edge N+1.
- Unmapped access: a read returns 16'h0000, a write is dropped, and bad_addr sets at that edge and stays set until reset.
- Reset mid-operation: in-flight reads are discarded. from_mem_data stays 0 until the first post-reset read has propagated.
- Every transition is synchronous to clk except reset.

Optional Feature:
- Macro: MEM_RO_REGION_EN.
- When defined:
  - Writes to addresses 0..ROM_WORDS-1 are dropped and set bad_addr.
  - The write-through slot returns the existing RAM word, not the write data.
  - Reads of the region are unaffected.
  - RAM may be preloaded by the bench.
- When undefined: all of 0..DEPTH-1 is writable, and ROM_WORDS is ignored.

Decomposition:
- Package mem_pkg holds:
  - word_t, a 16-bit type
  - MMIO_OUT_ADDR = 16'hFFFE
  - MMIO_CNT_ADDR = 16'hFFFF
  - MAX_READ_LATENCY = 4
- Sub-module mem_read_pipe: a parameterised delay line with READ_LATENCY-1 reset-to-zero stages of word_t. It passes data straight through when the depth is 0.
- The RAM array, address decode and MMIO registers stay in mem_responder.

Test Plan:
1. READ_LATENCY=1: write 16'hBEEF to addr 16'h0010, then read 16'h0010 on the next cycle -> from_mem_data = 16'hBEEF one cycle after the read address.
2. READ_LATENCY=3: reads of addrs 0,1,2 holding 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> the three values appear on consecutive cycles starting 3 cycles after the first address.
3. Release reset, then read 16'hFFFF at the 10th edge after release -> the counter value at that edge, 9. Write 16'hFFFE with data 16'h00A5 -> out_port = 16'h00A5 the next cycle.
4. Write to unmapped address 16'hF000 -> the RAM is unchanged and bad_addr = 1 and held. A read of 16'hF000 -> 16'h0000.
5. Assert reset while reads are in flight at READ_LATENCY=3 -> from_mem_data = 0 immediately. RAM data previously written at 16'h0010 is still readable after reset.
6. With MEM_RO_REGION_EN and ROM_WORDS=256: write 16'h1234 to addr 16'h0005, which was preloaded with 16'h0042 -> the read returns 16'h0042 and bad_addr = 1. A write to 16'h0100 succeeds.
